// File: rtl/clock_gen_pkg.sv
// Shared definitions for the clock-enable generator: channel FSM states,
// mode encodings and the divisor clamp helper.
package clock_gen_pkg;

  // Per-channel run state.
  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_DONE = 2'd2
  } ch_state_e;

  // Channel mode encodings (value of cfg_mode).
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Widest divisor the clamp helper handles; DIV_WIDTH must not exceed it.
  localparam int DIV_WIDTH_MAX = 32;

  // A divisor of 0 would make the period meaningless, so it behaves as 1.
  function automatic logic [DIV_WIDTH_MAX-1:0] clamp_divisor(
    input logic [DIV_WIDTH_MAX-1:0] div
  );
    return (div == '0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: IDLE/RUN/DONE FSM, down-counter, divisor/mode
// registers and registered tick/square/busy outputs.
module tick_channel
  import clock_gen_pkg::*;
#(
  parameter int DIV_WIDTH   = 24,
  parameter int DEFAULT_DIV = 1000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  input  logic                 i_mode,
  input  logic                 i_enable,
  output logic                 o_tick,
  output logic                 o_square,
  output logic                 o_busy
);

  localparam logic [DIV_WIDTH-1:0] RESET_DIV =
    DIV_WIDTH'(clamp_divisor(DIV_WIDTH_MAX'(DEFAULT_DIV)));
  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

  ch_state_e            r_state;
  ch_state_e            w_state_nxt;
  logic [DIV_WIDTH-1:0] r_count;
  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_mode;
  logic                 r_tick;
  logic                 r_square;
  logic                 r_busy;
  logic [DIV_WIDTH-1:0] w_load_div;
  logic [DIV_WIDTH-1:0] w_run_div;
  logic                 w_zero;
  logic                 w_fire;
  logic                 w_tick_nxt;
  logic                 w_square_nxt;
  logic                 w_busy_nxt;

  assign w_load_div = DIV_WIDTH'(clamp_divisor(DIV_WIDTH_MAX'(i_divisor)));

  // A write landing on this edge overrides the stored divisor immediately.
  assign w_run_div = i_load ? w_load_div : r_div;

  assign w_zero = (r_count == '0);

  // Period expiry; a config write on the same edge restarts the phase
  // instead, so it swallows the tick.
  assign w_fire = (r_state == CH_RUN) && i_enable && !i_load && w_zero;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: non-blocking (<=) in clocked blocks so every register samples pre-edge values.
    if (!reset) begin
      r_state <= CH_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decision; enable low always returns the channel to IDLE.
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      CH_IDLE: begin
        if (i_enable) w_state_nxt = CH_RUN;
      end
      CH_RUN: begin
        if (!i_enable) begin
          w_state_nxt = CH_IDLE;
        end else if (w_fire && (r_mode == MODE_ONESHOT)) begin
          w_state_nxt = CH_DONE;
        end
      end
      CH_DONE: begin
        if (!i_enable) w_state_nxt = CH_IDLE;
      end
      default: w_state_nxt = CH_IDLE;
    endcase
  end

  // Values the output registers take on the next edge.
  always_comb begin
    w_tick_nxt   = w_fire;
    w_square_nxt = r_square ^ w_fire;
    w_busy_nxt   = (w_state_nxt == CH_RUN);
  end

  // Divisor and mode storage, written by the config strobe in any state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_div  <= RESET_DIV;
      r_mode <= MODE_PERIODIC;
    end else if (i_load) begin
      r_div  <= w_load_div;
      r_mode <= i_mode;
    end
  end

  // Down-counter: loads D-1 on RUN entry, on a config restart and at
  // expiry; otherwise counts down in RUN and holds elsewhere.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_enable && ((r_state == CH_IDLE) ||
                              ((r_state == CH_RUN) && (i_load || w_zero)))) begin
      r_count <= w_run_div - DIV_ONE;
    end else if (i_enable && (r_state == CH_RUN)) begin
      r_count <= r_count - DIV_ONE;
    end
  end

  // Registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tick   <= 1'b0;
      r_square <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_tick   <= w_tick_nxt;
      r_square <= w_square_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign o_tick   = r_tick;
  assign o_square = r_square;
  assign o_busy   = r_busy;

endmodule

// File: rtl/clock_enable_generator.sv
// Multi-channel clock-enable generator: config handshake, channel decode
// and NUM_CHANNELS independent tick channels in the system clock domain.
module clock_enable_generator
  import clock_gen_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DIV_WIDTH    = 24,
  parameter int DEFAULT_DIV  = 1000,
  parameter int CH_IDX_W     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CH_IDX_W-1:0]     cfg_channel,
  input  logic [DIV_WIDTH-1:0]    cfg_divisor,
  input  logic                    cfg_mode,
  input  logic [NUM_CHANNELS-1:0] enable,
  output logic [NUM_CHANNELS-1:0] tick,
  output logic [NUM_CHANNELS-1:0] square,
  output logic [NUM_CHANNELS-1:0] busy
);

  logic                    r_cfg_ready;
  logic                    w_accept;
  logic [NUM_CHANNELS-1:0] w_load;

  assign w_accept = cfg_valid && r_cfg_ready;

  // Ready drops for the commit cycle after each accepted write and is
  // low while in reset, rising on the first edge after release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cfg_ready <= 1'b0;
    end else begin
      r_cfg_ready <= !w_accept;
    end
  end

  assign cfg_ready = r_cfg_ready;

  // One load strobe per channel; an out-of-range index matches none, so
  // the handshake completes and the data is dropped.
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    assign w_load[g] = w_accept && (cfg_channel == CH_IDX_W'(g));

    tick_channel #(
      .DIV_WIDTH   (DIV_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_channel (
      .clock     (clock),
      .reset     (reset),
      .i_load    (w_load[g]),
      .i_divisor (cfg_divisor),
      .i_mode    (cfg_mode),
      .i_enable  (enable[g]),
      .o_tick    (tick[g]),
      .o_square  (square[g]),
      .o_busy    (busy[g])
    );
  end

endmodule

// File: tb/tb_clock_enable_generator.sv
// Bench for clock_enable_generator: schedule-based reference model checked
// every cycle, plus directed scenarios with hand-computed timings.
module tb_clock_enable_generator;

  localparam int NCH   = 3;
  localparam int DW    = 24;
  localparam int DDIV  = 1000;
  localparam int CHW   = 2;

  logic           clock = 1'b0;
  logic           reset;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_channel;
  logic [DW-1:0]  cfg_divisor;
  logic           cfg_mode;
  logic [NCH-1:0] enable;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] square;
  logic [NCH-1:0] busy;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc   = 0;

  clock_enable_generator #(
    .NUM_CHANNELS (NCH),
    .DIV_WIDTH    (DW),
    .DEFAULT_DIV  (DDIV)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_channel (cfg_channel),
    .cfg_divisor (cfg_divisor),
    .cfg_mode    (cfg_mode),
    .enable      (enable),
    .tick        (tick),
    .square      (square),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // Edge counter: after edge n, cyc == n.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned clampd(input logic [DW-1:0] v);
    return (v == '0) ? 32'd1 : 32'(v);
  endfunction

  // ---------------- reference model ----------------
  // Each active channel keeps the absolute edge number of its next tick.
  int unsigned    m_div    [NCH];
  bit             m_mode   [NCH];
  bit             m_active [NCH];
  bit             m_hold   [NCH];
  longint         m_next   [NCH];
  logic [NCH-1:0] e_tick;
  logic [NCH-1:0] e_square;
  logic [NCH-1:0] e_busy;
  logic           e_ready;

  always @(posedge clock or negedge reset) begin : model
    if (!reset) begin
      e_ready <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_div[c]    <= DDIV;
        m_mode[c]   <= 1'b0;
        m_active[c] <= 1'b0;
        m_hold[c]   <= 1'b0;
        m_next[c]   <= 0;
        e_tick[c]   <= 1'b0;
        e_square[c] <= 1'b0;
        e_busy[c]   <= 1'b0;
      end
    end else begin
      automatic bit     acc = cfg_valid && e_ready;
      automatic longint now = cyc + 1;
      e_ready <= !acc;
      for (int c = 0; c < NCH; c++) begin
        automatic bit          ld  = acc && (int'(cfg_channel) == c);
        automatic int unsigned d   = ld ? clampd(cfg_divisor) : m_div[c];
        automatic bit          md  = ld ? cfg_mode : m_mode[c];
        automatic bit          act = m_active[c];
        automatic bit          hld = m_hold[c];
        automatic longint      nxt = m_next[c];
        automatic bit          tk  = 1'b0;
        if (!enable[c]) begin
          act = 1'b0;
          hld = 1'b0;
        end else if (!act && !hld) begin
          act = 1'b1;
          nxt = now + longint'(d);
        end else if (act) begin
          if (ld) begin
            nxt = now + longint'(d);
          end else if (now == nxt) begin
            tk = 1'b1;
            if (md) begin
              act = 1'b0;
              hld = 1'b1;
            end else begin
              nxt = now + longint'(d);
            end
          end
        end
        m_div[c]    <= d;
        m_mode[c]   <= md;
        m_active[c] <= act;
        m_hold[c]   <= hld;
        m_next[c]   <= nxt;
        e_tick[c]   <= tk;
        e_square[c] <= e_square[c] ^ tk;
        e_busy[c]   <= act;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("model tick[%0d]", c),   32'(tick[c]),   32'(e_tick[c]));
      check($sformatf("model square[%0d]", c), 32'(square[c]), 32'(e_square[c]));
      check($sformatf("model busy[%0d]", c),   32'(busy[c]),   32'(e_busy[c]));
    end
    check("model cfg_ready", 32'(cfg_ready), 32'(e_ready));
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a negedge; returns the edge number of the tick seen.
  task automatic wait_tick(input int c, input int budget, output longint at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (tick[c]) begin
        at = cyc;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_tick[%0d]: no tick within %0d cycles", c, budget);
  endtask

  // Issues one config write; acc_edge is the edge that accepts it.
  task automatic cfg_write(input int ch, input int d, input bit m, output longint acc_edge);
    int guard = 0;
    while (!cfg_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (guard == 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cfg_write: cfg_ready stayed low for %0d cycles", guard);
    end
    cfg_valid   = 1'b1;
    cfg_channel = CHW'(ch);
    cfg_divisor = DW'(d);
    cfg_mode    = m;
    acc_edge    = cyc + 1;
    @(negedge clock);
    cfg_valid   = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin : stim
    longint k, at, at2, a, last;
    int     n;
    cfg_valid   = 1'b0;
    cfg_channel = '0;
    cfg_divisor = '0;
    cfg_mode    = 1'b0;
    enable      = '0;
    reset       = 1'b1;
    #1 reset    = 1'b0;

    // Reset state.
    repeat (3) @(negedge clock);
    check("reset cfg_ready", 32'(cfg_ready), 0);
    check("reset tick", 32'(tick), 0);
    check("reset busy", 32'(busy), 0);
    reset = 1'b1;
    @(negedge clock);
    check("ready after release", 32'(cfg_ready), 1);

    // 1: default divisor, periodic, square period 2000.
    enable[0] = 1'b1;
    k = cyc + 1;
    wait_tick(0, 1100, at);
    check("t1 first tick latency", 32'(at - k), 1000);
    check("t1 square after tick 1", 32'(square[0]), 1);
    wait_tick(0, 1100, at2);
    check("t1 tick spacing", 32'(at2 - at), 1000);
    check("t1 square after tick 2", 32'(square[0]), 0);

    // 2: divisor 0 acts as 1 -> tick every cycle.
    cfg_write(1, 0, 1'b0, a);
    enable[1] = 1'b1;
    k = cyc + 1;
    wait_tick(1, 10, at);
    check("t2 first tick latency", 32'(at - k), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("t2 tick every cycle", 32'(tick[1]), 1);
      check("t2 busy", 32'(busy[1]), 1);
    end

    // 3: one-shot D=5, then re-arm by dropping enable.
    cfg_write(2, 5, 1'b1, a);
    enable[2] = 1'b1;
    k = cyc + 1;
    wait_tick(2, 20, at);
    check("t3 one-shot latency", 32'(at - k), 5);
    @(negedge clock);
    check("t3 tick single cycle", 32'(tick[2]), 0);
    check("t3 busy cleared", 32'(busy[2]), 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n += int'(tick[2]);
    end
    check("t3 no repeat tick", 32'(n), 0);
    enable[2] = 1'b0;
    @(negedge clock);
    enable[2] = 1'b1;
    k = cyc + 1;
    wait_tick(2, 20, at);
    check("t3 re-arm latency", 32'(at - k), 5);

    // 4: ch0 at D=8, write D=3 exactly on the expiry edge.
    cfg_write(0, 8, 1'b0, a);
    wait_tick(0, 20, at);
    check("t4 D=8 tick edge", 32'(at - a), 8);
    while (cyc < a + 15) @(negedge clock);
    check("t4 ready before collision", 32'(cfg_ready), 1);
    cfg_valid   = 1'b1;
    cfg_channel = CHW'(0);
    cfg_divisor = DW'(3);
    cfg_mode    = 1'b0;
    @(negedge clock);
    cfg_valid = 1'b0;
    check("t4 collision edge", 32'(cyc - a), 16);
    check("t4 no tick on collision", 32'(tick[0]), 0);
    check("t4 ready low commit", 32'(cfg_ready), 0);
    @(negedge clock);
    check("t4 ready back", 32'(cfg_ready), 1);
    wait_tick(0, 10, at);
    check("t4 next tick after write", 32'(at - (a + 16)), 3);
    last = at;

    // 5: out-of-range channel is accepted and ignored.
    cfg_write(NCH, 2, 1'b1, a);
    check("t5 ready low commit", 32'(cfg_ready), 0);
    check("t5 ch1 still ticking", 32'(tick[1]), 1);
    wait_tick(0, 10, at);
    wait_tick(0, 10, at2);
    check("t5 ch0 spacing", 32'(at2 - at), 3);
    check("t5 ch0 phase kept", 32'((at - last) % 3), 0);

    // 6: async reset between edges, then defaults restored.
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("t6 tick async clear", 32'(tick), 0);
    check("t6 square async clear", 32'(square), 0);
    check("t6 busy async clear", 32'(busy), 0);
    check("t6 ready async clear", 32'(cfg_ready), 0);
    @(negedge clock);
    reset = 1'b1;
    k = cyc + 1;
    @(negedge clock);
    check("t6 ready after release", 32'(cfg_ready), 1);
    wait_tick(0, 1100, at);
    check("t6 ch0 default divisor", 32'(at - k), 1000);
    check("t6 ch1 default divisor", 32'(tick[1]), 1);
    check("t6 ch2 default periodic", 32'(tick[2]), 1);

    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
